// File: rtl/mac_cmd_pkg.sv
// Shared definitions for the serial MAC driver: MAC command codes,
// driver FSM state encoding and the state-to-command mapping.
package mac_cmd_pkg;

  localparam logic [1:0] CMD_CLR      = 2'b00;
  localparam logic [1:0] CMD_SHIFT_AB = 2'b01;
  localparam logic [1:0] CMD_LOAD     = 2'b10;
  localparam logic [1:0] CMD_SHIFT_C  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_READ  = 3'd4,
    ST_RESP  = 3'd5
  } mac_state_e;

  // The MAC has no idle command, so idle-like states issue SHIFT_AB with
  // d_in held low: A/B fill with zeros and the accumulator is untouched.
  function automatic logic [1:0] cmd_for_state(input mac_state_e st);
    logic [1:0] cmd_v;
    cmd_v = CMD_SHIFT_AB;
    case (st)
      ST_CLR:  cmd_v = CMD_CLR;
      ST_LOAD: cmd_v = CMD_LOAD;
      ST_READ: cmd_v = CMD_SHIFT_C;
      default: cmd_v = CMD_SHIFT_AB;
    endcase
    return cmd_v;
  endfunction

endpackage

// File: rtl/mac_ser_shifter.sv
// Serial datapath for the MAC driver: bit counter with done pulse,
// parallel-in/serial-out operand shifter and serial-in/parallel-out
// result shifter.
module mac_ser_shifter
  import mac_cmd_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 shift,
  output logic                 piso_bit,
  input  logic                 cnt_en,
  output logic                 done,
  input  logic                 sipo_en,
  input  logic                 d_out,
  output logic [2*WIDTH-1:0]   sipo_word
);

  localparam int NB    = 2 * WIDTH;
  localparam int CNT_W = $clog2(NB);

  logic [NB-1:0]    piso_r;
  logic [NB-1:0]    piso_src_s;
  logic [NB-1:0]    piso_nxt_s;
  logic [NB-1:0]    sipo_r;
  logic [CNT_W-1:0] cnt_r;

  // Operand word is {a,b} sent LSB first, so b leaves before a. A load and
  // a shift can coincide (back-to-back term), hence the source mux.
  always_comb begin
    piso_src_s = load ? {a, b} : piso_r;
    piso_bit   = piso_src_s[0];
    if (shift) begin
      piso_nxt_s = {1'b0, piso_src_s[NB-1:1]};
    end else begin
      piso_nxt_s = piso_src_s;
    end
    done      = cnt_en && (cnt_r == CNT_W'(NB - 1));
    sipo_word = {sipo_r[NB-2:0], d_out};
  end

  // Operand shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      piso_r <= {NB{1'b0}};
    end else if (load || shift) begin
      piso_r <= piso_nxt_s;
    end
  end

  // Bit counter: runs 0..2W-1 while enabled, idles at zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!cnt_en || done) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Result shift register, MSB of the accumulator arrives first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sipo_r <= {NB{1'b0}};
    end else if (sipo_en) begin
      sipo_r <= sipo_word;
    end
  end

endmodule

// File: rtl/mac_serial_driver.sv
// Host-side initiator for the bit-serial MAC: takes operand pairs over a
// valid/ready interface, serialises them into the MAC, sequences the MAC
// commands and deserialises the accumulated dot product.
module mac_serial_driver
  import mac_cmd_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 op_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic [1:0]           mac_cmd,
  output logic                 mac_d_in,
  input  logic                 mac_d_out
);

  mac_state_e          state_r;
  mac_state_e          state_nxt_s;
  logic                first_r;
  logic                last_r;
  logic                op_ready_r;
  logic                res_valid_r;
  logic [2*WIDTH-1:0]  res_data_r;
  logic [1:0]          mac_cmd_r;
  logic                mac_d_in_r;

  logic                hs_s;
  logic                load_s;
  logic                shift_s;
  logic                cnt_en_s;
  logic                sipo_en_s;
  logic                done_s;
  logic                piso_bit_s;
  logic [2*WIDTH-1:0]  sipo_word_s;
  logic                op_ready_nxt_s;
  logic                res_valid_nxt_s;
  logic [1:0]          mac_cmd_nxt_s;
  logic                mac_d_in_nxt_s;
  logic                res_load_s;

  assign op_ready  = op_ready_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign mac_cmd   = mac_cmd_r;
  assign mac_d_in  = mac_d_in_r;

  assign hs_s      = op_valid && op_ready_r;
  assign load_s    = hs_s && (state_r == ST_IDLE);
  assign cnt_en_s  = (state_r == ST_SHIFT) || (state_r == ST_READ);
  assign sipo_en_s = (state_r == ST_READ);

  mac_ser_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .a         (op_a),
    .b         (op_b),
    .shift     (shift_s),
    .piso_bit  (piso_bit_s),
    .cnt_en    (cnt_en_s),
    .done      (done_s),
    .sipo_en   (sipo_en_s),
    .d_out     (mac_d_out),
    .sipo_word (sipo_word_s)
  );

  // Next state plus next values of the registered outputs; outputs are
  // derived from the next state so they line up with the state register.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_nxt_s = first_r ? ST_CLR : ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR:   state_nxt_s = ST_SHIFT;
      ST_SHIFT: state_nxt_s = done_s ? ST_LOAD : ST_SHIFT;
      ST_LOAD:  state_nxt_s = last_r ? ST_READ : ST_IDLE;
      ST_READ:  state_nxt_s = done_s ? ST_RESP : ST_READ;
      ST_RESP:  state_nxt_s = res_ready ? ST_IDLE : ST_RESP;
      default:  state_nxt_s = ST_IDLE;
    endcase

    shift_s         = (state_nxt_s == ST_SHIFT);
    op_ready_nxt_s  = (state_nxt_s == ST_IDLE);
    res_valid_nxt_s = (state_nxt_s == ST_RESP);
    mac_cmd_nxt_s   = cmd_for_state(state_nxt_s);
    mac_d_in_nxt_s  = shift_s ? piso_bit_s : 1'b0;
    res_load_s      = (state_r == ST_READ) && done_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs toward the producer, consumer and MAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_ready_r  <= 1'b1;
      res_valid_r <= 1'b0;
      res_data_r  <= {(2*WIDTH){1'b0}};
      mac_cmd_r   <= CMD_SHIFT_AB;
      mac_d_in_r  <= 1'b0;
    end else begin
      op_ready_r  <= op_ready_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      mac_cmd_r   <= mac_cmd_nxt_s;
      mac_d_in_r  <= mac_d_in_nxt_s;
      if (res_load_s) begin
        res_data_r <= sipo_word_s;
      end
    end
  end

  // first: readout destroys the accumulator, so the next product must
  // start with CLR. last: captured with each pair to pick LOAD's exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_r <= 1'b1;
      last_r  <= 1'b0;
    end else begin
      if (state_r == ST_CLR) begin
        first_r <= 1'b0;
      end else if ((state_r == ST_RESP) && res_ready) begin
        first_r <= 1'b1;
      end
      if (load_s) begin
        last_r <= op_last;
      end
    end
  end

endmodule

// File: tb/tb_mac_serial_driver.sv
// Directed bench for mac_serial_driver wired to a behavioural model of the
// bit-serial MAC (A/B shift chain, C accumulator, C shift-out).
module tb_mac_serial_driver;
  import mac_cmd_pkg::*;

  localparam int W = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           op_valid = 1'b0;
  logic           op_ready;
  logic [W-1:0]   op_a = 3'd0;
  logic [W-1:0]   op_b = 3'd0;
  logic           op_last = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [2*W-1:0] res_data;
  logic [1:0]     mac_cmd;
  logic           mac_d_in;
  logic           mac_d_out;

  // MAC model state
  logic [W-1:0]   ma = 3'd0;
  logic [W-1:0]   mb = 3'd0;
  logic [2*W-1:0] mc = 6'd0;

  int total = 0;
  int bad = 0;
  int clr_cnt = 0;

  mac_serial_driver #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_last   (op_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .mac_cmd   (mac_cmd),
    .mac_d_in  (mac_d_in),
    .mac_d_out (mac_d_out)
  );

  always #5 clk = ~clk;

  assign mac_d_out = mc[2*W-1];

  // Serial MAC model: acts on the command present before each edge.
  always @(posedge clk) begin
    case (mac_cmd)
      CMD_CLR: begin
        ma <= 3'd0;
        mb <= 3'd0;
        mc <= 6'd0;
      end
      CMD_SHIFT_AB: begin
        ma <= {mac_d_in, ma[W-1:1]};
        mb <= {ma[0], mb[W-1:1]};
      end
      CMD_LOAD:    mc <= mc + ({3'd0, ma} * {3'd0, mb});
      CMD_SHIFT_C: mc <= {mc[2*W-2:0], 1'b0};
      default:     mc <= mc;
    endcase
    if (mac_cmd == CMD_CLR) clr_cnt <= clr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a pair at a negedge once op_ready is seen; returns at the
  // negedge right after the handshake edge.
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    int n;
    n = 0;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("op_ready_timeout", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_last = last;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_last = 1'b0;
    @(negedge clk);
  endtask

  // Wait for a result, check it, accept it and check the return to IDLE.
  task automatic wait_result(input string tag, input logic [2*W-1:0] exp);
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("res_valid_timeout", 32'(res_valid), 32'd1);
    chk(tag, 32'(res_data), 32'(exp));
    res_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid_low", 32'(res_valid), 32'd0);
    chk("accept_ready_high", 32'(op_ready), 32'd1);
    res_ready = 1'b0;
  endtask

  initial begin
    logic exp_din [6];
    int c0;
    exp_din = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_mac_cmd", 32'(mac_cmd), 32'(CMD_SHIFT_AB));
    chk("rst_mac_d_in", 32'(mac_d_in), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single term 3*5, cycle-exact sequence
    send_pair(3'd3, 3'd5, 1'b1);
    chk("t1_clr", 32'(mac_cmd), 32'(CMD_CLR));
    chk("t1_busy", 32'(op_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_shift_cmd", 32'(mac_cmd), 32'(CMD_SHIFT_AB));
      chk("t1_d_in", 32'(mac_d_in), 32'(exp_din[i]));
    end
    @(negedge clk);
    chk("t1_load", 32'(mac_cmd), 32'(CMD_LOAD));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_read_cmd", 32'(mac_cmd), 32'(CMD_SHIFT_C));
      chk("t1_read_novalid", 32'(res_valid), 32'd0);
    end
    @(negedge clk);
    chk("t1_valid_latency", 32'(res_valid), 32'd1);
    wait_result("t1_result", 6'd15);

    // Two terms with wrap: 49+49 = 98 mod 64 = 34, one CLR only
    c0 = clr_cnt;
    send_pair(3'd7, 3'd7, 1'b0);
    send_pair(3'd7, 3'd7, 1'b1);
    wait_result("t2_result", 6'd34);
    chk("t2_clr_count", 32'(clr_cnt - c0), 32'd1);

    // Back-to-back products; second with res_ready held high throughout
    c0 = clr_cnt;
    send_pair(3'd2, 3'd3, 1'b1);
    wait_result("t3a_result", 6'd6);
    res_ready = 1'b1;
    send_pair(3'd1, 3'd1, 1'b1);
    wait_result("t3b_result", 6'd1);
    chk("t3_clr_count", 32'(clr_cnt - c0), 32'd2);

    // Consumer stalls 10 cycles in RESP
    send_pair(3'd3, 3'd5, 1'b1);
    begin
      int n;
      n = 0;
      while (!res_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("t4_timeout", 32'(res_valid), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(res_valid), 32'd1);
      chk("t4_hold_data", 32'(res_data), 32'd15);
      chk("t4_hold_busy", 32'(op_ready), 32'd0);
    end
    wait_result("t4_result", 6'd15);

    // Reset mid-SHIFT, then a fresh product must clear first
    send_pair(3'd3, 3'd5, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_cmd", 32'(mac_cmd), 32'(CMD_SHIFT_AB));
    chk("t5_op_ready", 32'(op_ready), 32'd1);
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_d_in", 32'(mac_d_in), 32'd0);
    c0 = clr_cnt;
    send_pair(3'd1, 3'd2, 1'b1);
    wait_result("t5_result", 6'd2);
    chk("t5_clr_count", 32'(clr_cnt - c0), 32'd1);

    // Gaps between terms keep the accumulator: 1+4+9 = 14
    send_pair(3'd1, 3'd1, 1'b0);
    repeat (12) @(negedge clk);
    chk("t6_idle_wait", 32'(op_ready), 32'd1);
    send_pair(3'd2, 3'd2, 1'b0);
    repeat (12) @(negedge clk);
    send_pair(3'd3, 3'd3, 1'b1);
    wait_result("t6_result", 6'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
